// File: rtl/exc_arbiter_pkg.sv
// rtl/exc_arbiter_pkg.sv - shared exception codes, CP0 addresses and Status/Cause field positions
package exc_arbiter_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd11 + 5'd1;

   // CP0 write address is {reg[4:0], sel[2:0]}; EPC is register 14, select 0.
   localparam logic [7:0] CP0_ADDR_EPC = 8'h70;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int ST_BEV = 22;
   localparam int IM_LO  = 8;
   localparam int IM_HI  = 15;

   typedef enum logic [1:0] {
      BADV_NONE  = 2'd0,
      BADV_PC    = 2'd1,
      BADV_DADDR = 2'd2
   } badv_sel_e;

   function automatic logic int_pending(input logic [31:0] cause, input logic [31:0] status);
      return status[ST_IE] & ~status[ST_EXL] & (|(cause[IM_HI:IM_LO] & status[IM_HI:IM_LO]));
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority exception cause encoder
module exc_prio_enc
   import exc_arbiter_pkg::*;
(
   input  logic       int_req,
   input  logic       if_adel,
   input  logic       ri,
   input  logic       ov,
   input  logic       sys,
   input  logic       bp,
   input  logic       ld_adel,
   input  logic       st_ades,
   output logic       exc,
   output logic [4:0] excode,
   output badv_sel_e  badv_sel
);

   always_comb begin
      exc      = 1'b1;
      excode   = EXC_INT;
      badv_sel = BADV_NONE;
      if (int_req) begin
         excode = EXC_INT;
      end else if (if_adel) begin
         excode   = EXC_ADEL;
         badv_sel = BADV_PC;
      end else if (ri) begin
         excode = EXC_RI;
      end else if (ov) begin
         excode = EXC_OV;
      end else if (sys) begin
         excode = EXC_SYS;
      end else if (bp) begin
         excode = EXC_BP;
      end else if (ld_adel) begin
         excode   = EXC_ADEL;
         badv_sel = BADV_DADDR;
      end else if (st_ades) begin
         excode   = EXC_ADES;
         badv_sel = BADV_DADDR;
      end else begin
         exc = 1'b0;
      end
   end

endmodule

// File: rtl/exc_arbiter.sv
// rtl/exc_arbiter.sv - commit-stage exception/eret arbiter with flush, redirect and refill hold
module exc_arbiter
   import exc_arbiter_pkg::*;
#(
   parameter int          HOLD_CYCLES = 2,
   parameter logic [31:0] VEC_BEV1    = 32'hBFC00380,
   parameter logic [31:0] VEC_BEV0    = 32'h80000180
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m_valid,
   input  logic        m_ready,
   input  logic [31:0] m_pc,
   input  logic        m_bd,
   input  logic        m_if_adel,
   input  logic        m_ri,
   input  logic        m_ov,
   input  logic        m_sys,
   input  logic        m_bp,
   input  logic        m_ld_adel,
   input  logic        m_st_ades,
   input  logic        m_eret,
   input  logic [31:0] m_daddr,
   input  logic        cp0_wen,
   input  logic [7:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic [31:0] cause,
   input  logic [31:0] status,
   input  logic [31:0] epc,
   output logic        ex_valid,
   output logic [4:0]  ex_excode,
   output logic        ex_bd,
   output logic [31:0] ex_epc,
   output logic [31:0] ex_badvaddr,
   output logic        ex_eret,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FLUSH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] hold_cnt;
   logic          int_req;
   logic          exc;
   logic [4:0]    excode;
   badv_sel_e     badv_sel;
   logic          commit;
   logic          event_take;
   logic [31:0]   epc_fwd;
   logic [31:0]   target;
   logic          unused_bits;

   assign int_req = int_pending(cause, status);
   assign commit  = m_valid & m_ready & (state == S_IDLE);

   exc_prio_enc u_prio (
      .int_req  (int_req),
      .if_adel  (m_if_adel),
      .ri       (m_ri),
      .ov       (m_ov),
      .sys      (m_sys),
      .bp       (m_bp),
      .ld_adel  (m_ld_adel),
      .st_ades  (m_st_ades),
      .exc      (exc),
      .excode   (excode),
      .badv_sel (badv_sel)
   );

   assign event_take = commit & (exc | m_eret);

   // Event fields are combinational so CP0 latches them on the commit edge.
   always_comb begin
      ex_valid    = event_take;
      ex_excode   = exc ? excode : 5'd0;
      ex_eret     = event_take & ~exc;
      ex_bd       = m_bd;
      ex_epc      = m_bd ? (m_pc - 32'd4) : m_pc;
      ex_badvaddr = 32'd0;
      case (badv_sel)
         BADV_PC:    ex_badvaddr = m_pc;
         BADV_DADDR: ex_badvaddr = m_daddr;
         default:    ex_badvaddr = 32'd0;
      endcase
   end

   // An mtc0 to EPC in the same cycle as eret must win over the stale register.
   assign epc_fwd = (cp0_wen && (cp0_addr == CP0_ADDR_EPC)) ? cp0_wdata : epc;
   assign target  = exc ? (status[ST_BEV] ? VEC_BEV1 : VEC_BEV0) : epc_fwd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         hold_cnt       <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (event_take) begin
                  state          <= S_FLUSH;
                  flush          <= 1'b1;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= target;
               end
            end
            S_FLUSH: begin
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
               hold_cnt       <= CW'(HOLD_CYCLES);
               state          <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
               hold_cnt <= hold_cnt - CW'(1);
               if (hold_cnt == CW'(1)) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign unused_bits = ^{cause[31:16], cause[7:0], status[31:23], status[21:16], status[7:2]};

endmodule

// File: tb/tb_exc_arbiter.sv
// tb/tb_exc_arbiter.sv - scoreboard bench for exc_arbiter with directed and random commits
module tb_exc_arbiter;
   import exc_arbiter_pkg::*;

   localparam int          H    = 2;
   localparam logic [31:0] VEC1 = 32'hBFC00380;
   localparam logic [31:0] VEC0 = 32'h80000180;

   typedef struct {
      logic        valid, ready;
      logic [31:0] pc;
      logic        bd, if_adel, ri, ov, sys, bp, ld_adel, st_ades, eret;
      logic [31:0] daddr;
      logic        cp0_wen;
      logic [7:0]  cp0_addr;
      logic [31:0] cp0_wdata, cause, status, epc;
   } stim_t;

   typedef struct {
      int          cyc;
      logic [4:0]  code;
      logic        bd;
      logic [31:0] epc, badv;
      logic        eret;
   } exp_ex_t;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
   } exp_rd_t;

   logic clk, resetn;
   logic m_valid, m_ready, m_bd, m_if_adel, m_ri, m_ov, m_sys, m_bp, m_ld_adel, m_st_ades, m_eret;
   logic [31:0] m_pc, m_daddr, cp0_wdata, cause, status, epc;
   logic cp0_wen;
   logic [7:0] cp0_addr;
   logic ex_valid, ex_bd, ex_eret, flush, redirect_valid;
   logic [4:0] ex_excode;
   logic [31:0] ex_epc, ex_badvaddr, redirect_pc;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int next_ok = 0;
   int code_tab [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
   exp_ex_t exq[$];
   exp_rd_t rdq[$];

   exc_arbiter #(.HOLD_CYCLES(H), .VEC_BEV1(VEC1), .VEC_BEV0(VEC0)) dut (
      .clk(clk), .resetn(resetn),
      .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_bd(m_bd),
      .m_if_adel(m_if_adel), .m_ri(m_ri), .m_ov(m_ov), .m_sys(m_sys), .m_bp(m_bp),
      .m_ld_adel(m_ld_adel), .m_st_ades(m_st_ades), .m_eret(m_eret), .m_daddr(m_daddr),
      .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
      .cause(cause), .status(status), .epc(epc),
      .ex_valid(ex_valid), .ex_excode(ex_excode), .ex_bd(ex_bd), .ex_epc(ex_epc),
      .ex_badvaddr(ex_badvaddr), .ex_eret(ex_eret), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s = '{valid: 1'b0, ready: 1'b1, pc: 32'd0, bd: 1'b0, if_adel: 1'b0, ri: 1'b0, ov: 1'b0,
            sys: 1'b0, bp: 1'b0, ld_adel: 1'b0, st_ades: 1'b0, eret: 1'b0, daddr: 32'd0,
            cp0_wen: 1'b0, cp0_addr: 8'd0, cp0_wdata: 32'd0, cause: 32'd0, status: 32'd0,
            epc: 32'd0};
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s = idle_stim();
      s.valid     = $urandom_range(0, 3) != 0;
      s.ready     = $urandom_range(0, 3) != 0;
      s.pc        = $urandom;
      s.bd        = $urandom_range(0, 1) == 1;
      s.if_adel   = $urandom_range(0, 9) == 0;
      s.ri        = $urandom_range(0, 9) == 0;
      s.ov        = $urandom_range(0, 9) == 0;
      s.sys       = $urandom_range(0, 9) == 0;
      s.bp        = $urandom_range(0, 9) == 0;
      s.ld_adel   = $urandom_range(0, 9) == 0;
      s.st_ades   = $urandom_range(0, 9) == 0;
      s.eret      = $urandom_range(0, 3) == 0;
      s.daddr     = $urandom;
      s.cp0_wen   = $urandom_range(0, 1) == 1;
      s.cp0_addr  = ($urandom_range(0, 1) == 1) ? CP0_ADDR_EPC : 8'($urandom);
      s.cp0_wdata = $urandom;
      s.cause     = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      s.status    = $urandom;
      s.epc       = $urandom;
      return s;
   endfunction

   // Reference: first set cause in priority order wins; acceptance window from cycle arithmetic.
   task automatic model(input stim_t s);
      logic [7:0] f;
      logic       ireq;
      int         hit;
      exp_ex_t    e;
      exp_rd_t    r;
      ireq = s.status[0] && !s.status[1] && ((s.cause[15:8] & s.status[15:8]) != 8'd0);
      f = {s.st_ades, s.ld_adel, s.bp, s.sys, s.ov, s.ri, s.if_adel, ireq};
      hit = -1;
      for (int i = 0; i < 8; i++) if (f[i] && hit < 0) hit = i;
      if (!(s.valid && s.ready && cyc >= next_ok)) return;
      if (hit < 0 && !s.eret) return;
      e.cyc  = cyc;
      e.code = (hit < 0) ? 5'd0 : 5'(code_tab[hit]);
      e.eret = (hit < 0);
      e.bd   = s.bd;
      e.epc  = s.bd ? s.pc - 32'd4 : s.pc;
      e.badv = (hit == 1) ? s.pc : ((hit >= 6) ? s.daddr : 32'd0);
      r.cyc  = cyc;
      if (hit >= 0) r.pc = s.status[22] ? VEC1 : VEC0;
      else r.pc = (s.cp0_wen && s.cp0_addr == CP0_ADDR_EPC) ? s.cp0_wdata : s.epc;
      exq.push_back(e);
      rdq.push_back(r);
      next_ok = cyc + 2 + H;
   endtask

   task automatic do_cycle(input stim_t s);
      @(negedge clk);
      cyc++;
      m_valid = s.valid;     m_ready = s.ready;       m_pc = s.pc;         m_bd = s.bd;
      m_if_adel = s.if_adel; m_ri = s.ri;             m_ov = s.ov;         m_sys = s.sys;
      m_bp = s.bp;           m_ld_adel = s.ld_adel;   m_st_ades = s.st_ades;
      m_eret = s.eret;       m_daddr = s.daddr;       cp0_wen = s.cp0_wen;
      cp0_addr = s.cp0_addr; cp0_wdata = s.cp0_wdata; cause = s.cause;
      status = s.status;     epc = s.epc;
      model(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(idle_stim());
   endtask

   // Monitor: samples mid low-phase, pops scoreboard entries when the DUT presents output.
   initial begin
      exp_ex_t e;
      exp_rd_t r;
      logic    exp_ex, exp_rd;
      forever begin
         @(negedge clk);
         #2;
         if (resetn) begin
            exp_ex = (exq.size() != 0) && (exq[0].cyc == cyc);
            check1("ex_valid", ex_valid, exp_ex);
            if (exp_ex) begin
               e = exq.pop_front();
               if (ex_valid) begin
                  check32("ex_excode", 32'(ex_excode), 32'(e.code));
                  check1("ex_bd", ex_bd, e.bd);
                  check32("ex_epc", ex_epc, e.epc);
                  check32("ex_badvaddr", ex_badvaddr, e.badv);
                  check1("ex_eret", ex_eret, e.eret);
               end
            end
            exp_rd = (rdq.size() != 0) && (rdq[0].cyc == cyc - 1);
            check1("redirect_valid", redirect_valid, exp_rd);
            check1("flush", flush, exp_rd);
            if (exp_rd) begin
               r = rdq.pop_front();
               if (redirect_valid) check32("redirect_pc", redirect_pc, r.pc);
            end
         end
      end
   end

   initial begin
      stim_t s;
      resetn = 1'b0;
      m_valid = 0; m_ready = 1; m_pc = 0; m_bd = 0; m_if_adel = 0; m_ri = 0; m_ov = 0;
      m_sys = 0; m_bp = 0; m_ld_adel = 0; m_st_ades = 0; m_eret = 0; m_daddr = 0;
      cp0_wen = 0; cp0_addr = 0; cp0_wdata = 0; cause = 0; status = 0; epc = 0;
      #2;
      check1("rst_ex_valid", ex_valid, 1'b0);
      check1("rst_flush", flush, 1'b0);
      check1("rst_redirect_valid", redirect_valid, 1'b0);
      check32("rst_redirect_pc", redirect_pc, 32'd0);
      #6 resetn = 1'b1;
      idle(2);

      // Overflow, BEV=1
      s = idle_stim(); s.valid = 1; s.ov = 1; s.pc = 32'h80001000; s.status = 32'h0040_0000;
      do_cycle(s); idle(4);

      // RI beats SYS, delay slot
      s = idle_stim(); s.valid = 1; s.ri = 1; s.sys = 1; s.bd = 1; s.pc = 32'h80000008;
      do_cycle(s); idle(4);

      // Interrupt beats store AdES
      s = idle_stim(); s.valid = 1; s.st_ades = 1; s.daddr = 32'h3; s.pc = 32'h80000100;
      s.status = 32'h0000_8001; s.cause = 32'h0000_8000;
      do_cycle(s); idle(4);

      // eret with same-cycle mtc0 EPC forward
      s = idle_stim(); s.valid = 1; s.eret = 1; s.epc = 32'h80002000;
      s.cp0_wen = 1; s.cp0_addr = CP0_ADDR_EPC; s.cp0_wdata = 32'h80003000;
      do_cycle(s); idle(4);

      // Stall: m_ready low holds off commit
      s = idle_stim(); s.valid = 1; s.ld_adel = 1; s.daddr = 32'h1001; s.ready = 0;
      do_cycle(s); do_cycle(s);
      s.ready = 1; do_cycle(s); idle(4);

      // Break then syscalls during FLUSH/HOLD are dropped; 4th cycle after accepted
      s = idle_stim(); s.valid = 1; s.bp = 1; s.pc = 32'h80000040;
      do_cycle(s);
      s.bp = 0; s.sys = 1;
      do_cycle(s); do_cycle(s); do_cycle(s); do_cycle(s);
      idle(4);

      // Reset during HOLD abandons it; commit right after release is accepted
      s = idle_stim(); s.valid = 1; s.bp = 1; s.pc = 32'h80000080;
      do_cycle(s); idle(2);
      #3 resetn = 1'b0;
      #1;
      check1("hold_rst_flush", flush, 1'b0);
      check1("hold_rst_redirect_valid", redirect_valid, 1'b0);
      check32("hold_rst_redirect_pc", redirect_pc, 32'd0);
      #3 resetn = 1'b1;
      next_ok = 0;
      s = idle_stim(); s.valid = 1; s.sys = 1; s.pc = 32'h80000200;
      do_cycle(s); idle(4);

      for (int i = 0; i < 600; i++) do_cycle(rand_stim());
      idle(6);
      check32("ex_queue_drained", 32'(exq.size()), 32'd0);
      check32("redirect_queue_drained", 32'(rdq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
  HOLD_CYCLES  2  cycles new commits are ignored after a redirect (pipeline refill).
  VEC_BEV1  32'hBFC00380  exception vector when Status.BEV=1.
  VEC_BEV0  32'h80000180  exception vector when Status.BEV=0.
REQ-002 SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge.
  resetn  in  1  asynchronous active-low reset.
  m_valid  in  1  instruction present in commit (MEM) stage.
  m_ready  in  1  commit stage advances this cycle.
  m_pc  in  32  instruction PC.
  m_bd  in  1  instruction is in a branch delay slot.
  m_if_adel  in  1  fetch address error.
  m_ri  in  1  reserved instruction.
  m_ov  in  1  arithmetic overflow.
  m_sys  in  1  syscall.
  m_bp  in  1  break.
  m_ld_adel  in  1  load address error.
  m_st_ades  in  1  store address error.
  m_eret  in  1  eret committing.
  m_daddr  in  32  data address of load/store.
  cp0_wen  in  1  mtc0 write this cycle.
  cp0_addr  in  8  mtc0 target.
  cp0_wdata  in  32  mtc0 data.
  cause  in  32  CP0 Cause.
  status  in  32  CP0 Status.
  epc  in  32  CP0 EPC.
  ex_valid  out  1  exception/eret event to CP0.
  ex_excode  out  5  exception code.
  ex_bd  out  1  branch-delay flag.
  ex_epc  out  32  exception PC.
  ex_badvaddr  out  32  faulting address.
  ex_eret  out  1  event is eret.
  flush  out  1  kill all younger pipeline stages.
  redirect_valid  out  1  fetch redirect pulse.
  redirect_pc  out  32  redirect target.

Function
REQ-003 SHALL compute int_req = Status.IE & !Status.EXL & |(Cause[15:8] & Status[15:8]).
REQ-004 SHALL commit an event only when m_valid & m_ready & state==IDLE; otherwise ex_valid=0.
REQ-005 SHALL select one cause by priority: Int(0) > fetch AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > load AdEL(4) > store AdES(5); eret lowest, only when no exception.
REQ-006 SHALL drive ex_* combinationally in the commit cycle, so CP0 captures them on the same edge.
REQ-007 SHALL set ex_epc = m_bd ? m_pc-4 : m_pc (32-bit wrap), ex_bd = m_bd.
REQ-008 SHALL set ex_badvaddr = m_pc for fetch AdEL, m_daddr for load AdEL/store AdES, 0 otherwise.
REQ-009 SHALL set ex_eret=1 and ex_excode=0 for eret; ex_valid=1.
REQ-010 SHALL use FSM IDLE -> FLUSH (1 cycle) -> HOLD (HOLD_CYCLES cycles) -> IDLE, entered on any committed event.
REQ-011 SHALL assert flush and redirect_valid for exactly the FLUSH cycle, both registered.
REQ-012 SHALL set redirect_pc for exceptions = Status.BEV ? VEC_BEV1 : VEC_BEV0, sampled at commit.
REQ-013 SHALL set redirect_pc for eret = epc, but cp0_wdata when cp0_wen & cp0_addr==EPC in the commit cycle (forward).
REQ-014 SHALL ignore m_valid during FLUSH/HOLD; HOLD counter counts down to 0 then returns IDLE; HOLD_CYCLES=0 skips HOLD.
REQ-015 SHALL hold a deasserted int_req with no latching: interrupt taken only if int_req true in the commit cycle.
REQ-016 SHALL drop m_ready-low cycles without commit; the event commits once when m_ready rises.

Reset
REQ-017 SHALL on resetn low asynchronously enter IDLE, clear HOLD counter, flush=0, redirect_valid=0, redirect_pc=0.
REQ-018 SHALL abandon an in-progress FLUSH/HOLD on reset with no redirect pulse after release.

Structure
REQ-019 SHALL take excode constants, CP0 address constants, Status/Cause field positions from the shared defines header.
REQ-020 SHALL be one module; priority encoder may be a sub-module exc_prio_enc.

Verification
REQ-021 SHALL cover: m_ov=1, m_pc=0x80001000, m_bd=0, BEV=1 -> ex_excode=12, ex_epc=0x80001000, next cycle redirect_pc=0xBFC00380, flush 1 cycle.
REQ-022 SHALL cover: m_ri & m_sys & m_bd=1, m_pc=0x80000008 -> ex_excode=10, ex_epc=0x80000004, ex_bd=1.
REQ-023 SHALL cover: IE=1, EXL=0, IM[7]=1, IP[7]=1, m_st_ades, m_daddr=0x3 -> excode=0, ex_badvaddr=0.
REQ-024 SHALL cover: eret with epc=0x80002000 and same-cycle mtc0 EPC=0x80003000 -> redirect_pc=0x80003000, ex_eret=1.
REQ-025 SHALL cover: m_bp commit then m_sys on the 2 following cycles -> only one ex_valid; next commit after 3 cycles accepted.
REQ-026 SHALL cover: resetn low during HOLD -> IDLE immediately, no redirect after release.
